draw_scheduler: RTL and testbench

Command sequencer in front of the line-draw and fill engines. It queues shape draw commands from the host decoder and dispatches them one at a time: line engine only, fill engine only, or outline then fill. It waits for each engine's completion pulse before issuing the next step, then retires the command with its ID. Sits between the command decoder and the line/fill engine start/done handshakes.

---
 rtl/draw_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_draw_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : draw_scheduler
// Description : Queues shape draw commands and sequences them through the
//               line and fill engines, retiring each with its shape ID.
//               Optional watchdog enabled by DRAW_SCHED_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module draw_scheduler #(
    parameter int DEPTH     = 4,
    parameter int ID_W      = 4,
    parameter int TO_CYCLES = 1023
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [ID_W-1:0]              cmd_id,
    output logic                         line_start,
    input  logic                         line_done,
    output logic                         fill_en,
    input  logic                         fill_done,
    output logic                         busy,
    output logic [ID_W-1:0]              active_id,
    output logic                         cmd_done,
    output logic [ID_W-1:0]              done_id,
    output logic                         err,
    output logic [$clog2(DEPTH+1)-1:0]   queue_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    localparam logic [1:0] C_OP_LINE = 2'b00;
    localparam logic [1:0] C_OP_FILL = 2'b01;
    localparam logic [1:0] C_OP_LF   = 2'b10;

    localparam logic [2:0] C_ST_IDLE      = 3'd0;
    localparam logic [2:0] C_ST_POP       = 3'd1;
    localparam logic [2:0] C_ST_LINE_GO   = 3'd2;
    localparam logic [2:0] C_ST_LINE_WAIT = 3'd3;
    localparam logic [2:0] C_ST_FILL_GO   = 3'd4;
    localparam logic [2:0] C_ST_FILL_WAIT = 3'd5;
    localparam logic [2:0] C_ST_RETIRE    = 3'd6;

    logic [1:0]      op_mem_q [DEPTH];
    logic [ID_W-1:0] id_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [2:0]       state_q,  state_d;
    logic [1:0]       cur_op_q, cur_op_d;
    logic [ID_W-1:0]  cur_id_q, cur_id_d;
    logic             to_err_q, to_err_d;

    logic w_push;
    logic w_pop;
    logic w_timeout;

    assign cmd_ready = (count_q < C_DEPTH);
    assign w_push    = cmd_valid && cmd_ready;

`ifdef DRAW_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYCLES + 1);

    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;

    // Counter is zero in every non-WAIT state, so entry into a WAIT state starts from 0.
    always_comb begin
        wait_cnt_d = '0;
        if (state_q == C_ST_LINE_WAIT || state_q == C_ST_FILL_WAIT) begin
            wait_cnt_d = wait_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign w_timeout = (wait_cnt_q == TO_W'(TO_CYCLES - 1));
`else
    logic w_unused_to;
    assign w_unused_to = (TO_CYCLES == 0);
    assign w_timeout   = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cur_op_d = cur_op_q;
        cur_id_d = cur_id_q;
        to_err_d = 1'b0;
        w_pop    = 1'b0;
        case (state_q)
            C_ST_IDLE: begin
                if (count_q != '0) begin
                    w_pop    = 1'b1;
                    cur_op_d = op_mem_q[rd_ptr_q];
                    cur_id_d = id_mem_q[rd_ptr_q];
                    state_d  = C_ST_POP;
                end
            end
            C_ST_POP: begin
                case (cur_op_q)
                    C_OP_LINE, C_OP_LF: state_d = C_ST_LINE_GO;
                    C_OP_FILL:          state_d = C_ST_FILL_GO;
                    default:            state_d = C_ST_IDLE;
                endcase
            end
            C_ST_LINE_GO: state_d = C_ST_LINE_WAIT;
            C_ST_LINE_WAIT: begin
                // line_done wins over a coincident fill_done here.
                if (line_done) begin
                    state_d = (cur_op_q == C_OP_LF) ? C_ST_FILL_GO : C_ST_RETIRE;
                end else if (w_timeout) begin
                    state_d  = C_ST_IDLE;
                    to_err_d = 1'b1;
                end
            end
            C_ST_FILL_GO: state_d = C_ST_FILL_WAIT;
            C_ST_FILL_WAIT: begin
                if (fill_done) begin
                    state_d = C_ST_RETIRE;
                end else if (w_timeout) begin
                    state_d  = C_ST_IDLE;
                    to_err_d = 1'b1;
                end
            end
            C_ST_RETIRE: state_d = C_ST_IDLE;
            default:     state_d = C_ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = w_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            op_mem_q[wr_ptr_q] <= cmd_op;
            id_mem_q[wr_ptr_q] <= cmd_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= C_ST_IDLE;
            cur_op_q <= '0;
            cur_id_q <= '0;
            to_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            cur_op_q <= cur_op_d;
            cur_id_q <= cur_id_d;
            to_err_q <= to_err_d;
        end
    end

    assign line_start  = (state_q == C_ST_LINE_GO);
    assign fill_en     = (state_q == C_ST_FILL_GO);
    assign busy        = (state_q != C_ST_IDLE);
    assign active_id   = busy ? cur_id_q : '0;
    assign cmd_done    = (state_q == C_ST_RETIRE);
    assign done_id     = cmd_done ? cur_id_q : '0;
    assign err         = ((state_q == C_ST_POP) && (cur_op_q == 2'b11)) || to_err_q;
    assign queue_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_draw_scheduler
// Description : Directed self-checking bench for draw_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_draw_scheduler;

`ifdef DRAW_SCHED_TIMEOUT_EN
    localparam int TB_TO = 16;
`else
    localparam int TB_TO = 1023;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_id = 4'd0;
    logic       line_start;
    logic       line_done = 1'b0;
    logic       fill_en;
    logic       fill_done = 1'b0;
    logic       busy;
    logic [3:0] active_id;
    logic       cmd_done;
    logic [3:0] done_id;
    logic       err;
    logic [2:0] queue_count;

    int checks = 0;
    int errors = 0;
    int n_line = 0, n_fill = 0, n_done = 0, n_err = 0;
    int b_line, b_fill, b_done, b_err;

    draw_scheduler #(.DEPTH(4), .ID_W(4), .TO_CYCLES(TB_TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_id(cmd_id),
        .line_start(line_start), .line_done(line_done),
        .fill_en(fill_en), .fill_done(fill_done),
        .busy(busy), .active_id(active_id),
        .cmd_done(cmd_done), .done_id(done_id),
        .err(err), .queue_count(queue_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (line_start) n_line++;
        if (fill_en)    n_fill++;
        if (cmd_done)   n_done++;
        if (err)        n_err++;
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_line = n_line; b_fill = n_fill; b_done = n_done; b_err = n_err;
    endtask

    initial begin
        // ---- reset ----
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", queue_count, 0);
        chk("rst_err", err, 0);
        chk("rst_done", cmd_done, 0);
        chk("rst_active", active_id, 0);
        chk("rst_done_id", done_id, 0);
        chk("rst_line", line_start, 0);
        chk("rst_fill", fill_en, 0);

        // ---- 1: LINE id=3 ----
        snap();
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_id = 4'd3;
        step();                                   // E0
        cmd_valid = 1'b0;
        chk("t1_count_e0", queue_count, 1);
        chk("t1_busy_e0", busy, 0);
        chk("t1_ls_e0", line_start, 0);
        step();                                   // E1 -> POP
        chk("t1_busy_pop", busy, 1);
        chk("t1_active_pop", active_id, 3);
        chk("t1_count_pop", queue_count, 0);
        chk("t1_ls_pop", line_start, 0);
        step();                                   // E2 -> LINE_GO
        chk("t1_ls_go", line_start, 1);
        step();
        chk("t1_ls_wait", line_start, 0);
        step(4);
        line_done = 1'b1;
        chk("t1_no_done_yet", cmd_done, 0);
        step();
        line_done = 1'b0;
        chk("t1_cmd_done", cmd_done, 1);
        chk("t1_done_id", done_id, 3);
        step();
        chk("t1_done_clr", cmd_done, 0);
        chk("t1_done_id_clr", done_id, 0);
        chk("t1_idle", busy, 0);
        chk("t1_n_line", n_line - b_line, 1);
        chk("t1_n_fill", n_fill - b_fill, 0);
        chk("t1_n_done", n_done - b_done, 1);

        // ---- 2: LINE_FILL id=7 ----
        snap();
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_id = 4'd7;
        step();
        cmd_valid = 1'b0;
        step();
        chk("t2_busy_pop", busy, 1);
        step();
        chk("t2_ls", line_start, 1);
        chk("t2_busy_lgo", busy, 1);
        step(3);
        chk("t2_busy_lwait", busy, 1);
        chk("t2_fill_early", fill_en, 0);
        line_done = 1'b1;
        step();
        line_done = 1'b0;
        chk("t2_fill_en", fill_en, 1);
        chk("t2_busy_fgo", busy, 1);
        chk("t2_no_done", cmd_done, 0);
        step(2);
        chk("t2_fill_once", fill_en, 0);
        chk("t2_busy_fwait", busy, 1);
        fill_done = 1'b1;
        step();
        fill_done = 1'b0;
        chk("t2_cmd_done", cmd_done, 1);
        chk("t2_done_id", done_id, 7);
        chk("t2_busy_ret", busy, 1);
        step();
        chk("t2_idle", busy, 0);
        chk("t2_n_line", n_line - b_line, 1);
        chk("t2_n_fill", n_fill - b_fill, 1);

        // ---- 3: six FILL commands against a depth-4 queue ----
        snap();
        cmd_valid = 1'b1; cmd_op = 2'b01;
        for (int i = 1; i <= 5; i++) begin
            cmd_id = 4'(i);
            step();
        end
        cmd_id = 4'd6;
        chk("t3_full_count", queue_count, 4);
        chk("t3_full_ready", cmd_ready, 0);
        chk("t3_active1", active_id, 1);
        step(2);
        chk("t3_hold_count", queue_count, 4);
        chk("t3_hold_ready", cmd_ready, 0);
        fill_done = 1'b1;
        step();
        fill_done = 1'b0;
        chk("t3_done1", cmd_done, 1);
        chk("t3_done_id1", done_id, 1);
        step(2);
        chk("t3_pop2_active", active_id, 2);
        chk("t3_pop2_count", queue_count, 3);
        chk("t3_pop2_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        chk("t3_refill_count", queue_count, 4);
        for (int k = 2; k <= 6; k++) begin
            for (int t = 0; t < 20 && !fill_en; t++) step();
            chk("t3_fill_seen", fill_en, 1);
            chk("t3_active", active_id, k);
            step();
            fill_done = 1'b1;
            step();
            fill_done = 1'b0;
            chk("t3_done", cmd_done, 1);
            chk("t3_done_id", done_id, k);
        end
        step();
        chk("t3_empty", queue_count, 0);
        chk("t3_idle", busy, 0);
        chk("t3_n_done", n_done - b_done, 6);

        // ---- 4: reserved opcode, then FILL id=2; spurious fill_done ----
        fill_done = 1'b1;
        step();
        fill_done = 1'b0;
        chk("t4_spur_busy", busy, 0);
        chk("t4_spur_done", cmd_done, 0);
        snap();
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_id = 4'd9;
        step();
        cmd_op = 2'b01; cmd_id = 4'd2;
        step();
        cmd_valid = 1'b0;
        chk("t4_err", err, 1);
        chk("t4_err_active", active_id, 9);
        chk("t4_count", queue_count, 1);
        step();
        chk("t4_err_clr", err, 0);
        chk("t4_idle", busy, 0);
        chk("t4_no_done9", cmd_done, 0);
        step();
        chk("t4_pop2", active_id, 2);
        step();
        chk("t4_fill_en", fill_en, 1);
        step();
        fill_done = 1'b1;
        step();
        fill_done = 1'b0;
        chk("t4_done", cmd_done, 1);
        chk("t4_done_id", done_id, 2);
        step();
        chk("t4_n_done", n_done - b_done, 1);
        chk("t4_n_err", n_err - b_err, 1);

        // ---- 5: reset in FILL_WAIT with two entries queued ----
        snap();
        cmd_valid = 1'b1; cmd_op = 2'b01;
        cmd_id = 4'd4; step();
        cmd_id = 4'd5; step();
        cmd_id = 4'd6; step();
        cmd_valid = 1'b0;
        step();
        chk("t5_count", queue_count, 2);
        chk("t5_busy", busy, 1);
        chk("t5_active", active_id, 4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_rst_count", queue_count, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", cmd_done, 0);
        chk("t5_rst_active", active_id, 0);
        chk("t5_rst_ready", cmd_ready, 1);
        fill_done = 1'b1;
        step();
        fill_done = 1'b0;
        chk("t5_late_busy", busy, 0);
        chk("t5_late_done", cmd_done, 0);
        step(2);
        chk("t5_still_idle", busy, 0);
        chk("t5_n_done", n_done - b_done, 0);
        chk("t5_n_err", n_err - b_err, 0);

`ifdef DRAW_SCHED_TIMEOUT_EN
        // ---- 6: line timeout on LINE_FILL ----
        snap();
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_id = 4'd1;
        step();
        cmd_valid = 1'b0;
        step(2);
        chk("t6_ls", line_start, 1);
        step();                                   // entered LINE_WAIT
        for (int i = 1; i <= 15; i++) begin
            step();
            chk("t6_err_early", err, 0);
        end
        step();
        chk("t6_err", err, 1);
        chk("t6_idle", busy, 0);
        step();
        chk("t6_err_clr", err, 0);
        chk("t6_n_fill", n_fill - b_fill, 0);
        chk("t6_n_done", n_done - b_done, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
